// File: rtl/dbg_guv_pkg.sv
// Shared channel encoding for the guv debug log path.
// Channel index doubles as the TUSER tag on the merged log stream.
package dbg_guv_pkg;

    localparam int NUM_LOG_CH = 5;

    typedef enum logic [2:0] {
        LOG_RDATA  = 3'd0,
        LOG_WDATA  = 3'd1,
        LOG_RADDR  = 3'd2,
        LOG_AWADDR = 3'd3,
        LOG_RESP   = 3'd4
    } log_ch_e;

endpackage

// File: rtl/dbg_log_arbiter_rr_arbiter.sv
// Work-conserving round-robin arbiter: grants the first request at or after
// the pointer, then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    // Scan from the pointer with wrap; idle or masked requesters are skipped.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (advance && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/dbg_log_arbiter.sv
// Merges the five guv debug log streams into one tagged AXI-Stream output
// through a single register slot, counting every delivered beat.
module dbg_log_arbiter
    import dbg_guv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LOG_CH-1:0] chan_en,

    input  logic [DATA_WIDTH-1:0] log_TDATA_rdata,
    input  logic [DEST_WIDTH-1:0] log_TDEST_rdata,
    input  logic                  log_TVALID_rdata,
    output logic                  log_TREADY_rdata,

    input  logic [DATA_WIDTH-1:0] log_TDATA_wdata,
    input  logic                  log_TVALID_wdata,
    output logic                  log_TREADY_wdata,

    input  logic [DATA_WIDTH-1:0] log_TDATA_raddr,
    input  logic                  log_TVALID_raddr,
    output logic                  log_TREADY_raddr,

    input  logic [DATA_WIDTH-1:0] log_TDATA_awaddr,
    input  logic                  log_TVALID_awaddr,
    output logic                  log_TREADY_awaddr,

    input  logic [DATA_WIDTH-1:0] log_TDATA_resp,
    input  logic                  log_TVALID_resp,
    output logic                  log_TREADY_resp,

    output logic [DATA_WIDTH-1:0] log_out_TDATA,
    output logic [DEST_WIDTH-1:0] log_out_TDEST,
    output logic [2:0]            log_out_TUSER,
    output logic                  log_out_TVALID,
    input  logic                  log_out_TREADY,

    output logic [CNT_WIDTH-1:0]  beat_count
);

    logic [NUM_LOG_CH-1:0] valid_vec;
    logic [NUM_LOG_CH-1:0] req;
    logic [NUM_LOG_CH-1:0] grant;
    logic [2:0]            grant_idx;
    logic [DATA_WIDTH-1:0] data_arr [NUM_LOG_CH];
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  slot_free;
    logic                  arb_go;

    assign valid_vec = {log_TVALID_resp, log_TVALID_awaddr, log_TVALID_raddr,
                        log_TVALID_wdata, log_TVALID_rdata};
    assign data_arr[LOG_RDATA]  = log_TDATA_rdata;
    assign data_arr[LOG_WDATA]  = log_TDATA_wdata;
    assign data_arr[LOG_RADDR]  = log_TDATA_raddr;
    assign data_arr[LOG_AWADDR] = log_TDATA_awaddr;
    assign data_arr[LOG_RESP]   = log_TDATA_resp;

    assign req       = valid_vec & chan_en;
    assign slot_free = !log_out_TVALID || log_out_TREADY;
    // Holding arbitration off during reset keeps every TREADY low.
    assign arb_go    = slot_free && rst;

    rr_arbiter #(.N(NUM_LOG_CH)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (arb_go),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign log_TREADY_rdata  = grant[LOG_RDATA];
    assign log_TREADY_wdata  = grant[LOG_WDATA];
    assign log_TREADY_raddr  = grant[LOG_RADDR];
    assign log_TREADY_awaddr = grant[LOG_AWADDR];
    assign log_TREADY_resp   = grant[LOG_RESP];

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_LOG_CH; i++) begin
            if (grant[i]) mux_data = mux_data | data_arr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            log_out_TVALID <= 1'b0;
            log_out_TDATA  <= '0;
            log_out_TDEST  <= '0;
            log_out_TUSER  <= '0;
            beat_count     <= '0;
        end else begin
            if (log_out_TVALID && log_out_TREADY) beat_count <= beat_count + CNT_WIDTH'(1);
            if (|grant) begin
                log_out_TVALID <= 1'b1;
                log_out_TDATA  <= mux_data;
                log_out_TDEST  <= grant[LOG_RDATA] ? log_TDEST_rdata : '0;
                log_out_TUSER  <= grant_idx;
            end else if (slot_free) begin
                log_out_TVALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dbg_log_arbiter.md
Name: dbg_log_arbiter

Overview:
Merges the five per-channel debug log streams (rdata, wdata, raddr, awaddr, resp) produced by the guv datapath into a single AXI-Stream log output. Fair round-robin arbitration; every beat is tagged with its source channel. Sits between the datapath log ports and the single log sink (log FIFO / DMA), configured by a channel-enable mask from the control FSM.

Parameters:
DATA_WIDTH, 64, width of every log TDATA.
DEST_WIDTH, 16, width of rdata TDEST carried through.
CNT_WIDTH, 32, width of forwarded-beat counter.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 resets)
chan_en  in  5  per-channel enable; bit0 rdata, bit1 wdata, bit2 raddr, bit3 awaddr, bit4 resp
log_TDATA_rdata / log_TDEST_rdata / log_TVALID_rdata  in  DATA_WIDTH/DEST_WIDTH/1  rdata log stream
log_TREADY_rdata  out  1  rdata accept
log_TDATA_wdata, log_TVALID_wdata  in  DATA_WIDTH/1 ; log_TREADY_wdata  out  1  wdata log stream
log_TDATA_raddr, log_TVALID_raddr  in  DATA_WIDTH/1 ; log_TREADY_raddr  out  1  raddr log stream
log_TDATA_awaddr, log_TVALID_awaddr  in  DATA_WIDTH/1 ; log_TREADY_awaddr  out  1  awaddr log stream
log_TDATA_resp, log_TVALID_resp  in  DATA_WIDTH/1 ; log_TREADY_resp  out  1  resp log stream
log_out_TDATA  out  DATA_WIDTH  merged beat data
log_out_TDEST  out  DEST_WIDTH  rdata TDEST; 0 for other channels
log_out_TUSER  out  3  source channel index 0..4
log_out_TVALID  out  1  merged beat valid
log_out_TREADY  in  1  sink accept
beat_count  out  CNT_WIDTH  total beats delivered on log_out

Behaviour:
- Reset (rst==0 at clk edge): log_out_TVALID=0, TDATA/TDEST/TUSER=0, beat_count=0, RR pointer=0 (rdata highest priority first). All log_TREADY_* are 0 while rst==0. A held beat is discarded.
- Single output register slot. slot_free = !log_out_TVALID || log_out_TREADY.
- Request vector req[i] = log_TVALID_i && chan_en[i].
- Grant combinational: when slot_free and |req, grant one-hot = first set req at or after pointer, wrapping 4->0. log_TREADY_i = grant[i] (combinational, no dependence on TVALID of other channels beyond arbitration). Disabled channels never see TREADY=1.
- On grant edge: slot loads TDATA/TDEST(rdata only, else 0)/TUSER=i, TVALID=1; pointer <= (i+1) mod 5.
- No grant and slot_free: TVALID<=0 next cycle; pointer unchanged.
- Latency: input handshake to log_out_TVALID = 1 cycle. Throughput 1 beat/cycle under continuous TREADY.
- Backpressure: while log_out_TVALID && !log_out_TREADY, output fields held stable, all input TREADY=0.
- beat_count increments by 1 on each log_out_TVALID && log_out_TREADY; wraps at 2^CNT_WIDTH-1 -> 0.
- chan_en change: takes effect on the next arbitration; a beat already in the slot is still delivered.
- Pointer skips idle/disabled channels (work-conserving); a continuously requesting channel waits at most 4 grants.
- Input protocol: arbiter relies on upstream holding TVALID/TDATA until TREADY; no internal buffering per channel.

Decomposition:
- dbg_guv_pkg: typedef enum logic [2:0] log_ch_e {LOG_RDATA=0, LOG_WDATA=1, LOG_RADDR=2, LOG_AWADDR=3, LOG_RESP=4}; localparam NUM_LOG_CH=5.
- Sub-module rr_arbiter (parameter N=5): req[N], advance strobe, grant one-hot, registered pointer; same rst semantics. Top holds slot register, muxing, counter.

Test Plan:
- Only wdata valid, TDATA=64'hA5A5, chan_en=5'h1F, TREADY=1 -> TREADY_wdata=1 same cycle; next cycle log_out TDATA=64'hA5A5, TUSER=1, TDEST=0; beat_count=1.
- All five valid continuously, TREADY=1, pointer=0 -> TUSER sequence 0,1,2,3,4,0,... one beat per cycle; beat_count=10 after 10 cycles.
- rdata TDEST=16'h0042 granted, then log_out_TREADY=0 for 3 cycles -> output held TDATA/TDEST=0042/TUSER=0 stable, all input TREADY=0; delivered once on release.
- chan_en=5'b10101, all valid -> only TUSER 0,2,4 appear, TREADY_wdata and TREADY_awaddr never 1.
- rst=0 asserted while beat held with TREADY=0 -> next cycle TVALID=0, beat_count=0; after release first grant is rdata (pointer 0).
- Preload beat_count to 2^32-1 (via 2^32-1 beats or force) -> next accepted beat gives 0.
